// File: rtl/wb_sequencer.sv
// Write-back sequencer: arbitrates ALU results and load returns onto a single
// register-file write port, splitting MUL results into low/high writes.
module wb_sequencer #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [5:0]            alu_op,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic [RA_W-1:0]       alu_rdst1,
  input  logic [RA_W-1:0]       alu_rdst2,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic [RA_W-1:0]       ld_rdst,
  output logic                  rf_we,
  output logic [RA_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  busy,
  output logic                  op_err,
  output logic [15:0]           wb_count
);

  typedef enum logic [1:0] {IDLE, WR_SINGLE, WR_LO, WR_HI} state_t;

  state_t              state_q;
  logic                ld_prio_q;
  logic [RA_W-1:0]     hi_addr_q;
  logic [DATA_W-1:0]   hi_data_q;
  logic                rf_we_q;
  logic [RA_W-1:0]     rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic                op_err_q;
  logic [15:0]         wb_count_q;

  logic ld_grant, alu_grant;
  logic op_single, op_mul, op_illegal;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    ld_grant  = 1'b0;
    alu_grant = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (ld_valid && (!alu_valid || ld_prio_q))
        ld_grant = 1'b1;
      else if (alu_valid)
        alu_grant = 1'b1;
    end
  end

  always_comb begin
    op_single  = (alu_op <= 6'd1) ||
                 (alu_op >= 6'd4 && alu_op <= 6'd16 && alu_op != 6'd7);
    op_mul     = (alu_op == 6'd7);
    op_illegal = (alu_op > 6'd16);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_prio_q  <= 1'b1;
      hi_addr_q  <= '0;
      hi_data_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      op_err_q   <= 1'b0;
      wb_count_q <= '0;
    end else begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      op_err_q   <= alu_grant && op_illegal;
      wb_count_q <= wb_count_q + 16'(rf_we_q);
      if (ld_grant || alu_grant)
        ld_prio_q <= alu_grant;

      case (state_q)
        IDLE: begin
          if (ld_grant) begin
            state_q    <= WR_SINGLE;
            rf_we_q    <= 1'b1;
            rf_waddr_q <= ld_rdst;
            rf_wdata_q <= ld_data;
          end else if (alu_grant && (op_single || op_mul)) begin
            state_q    <= op_mul ? WR_LO : WR_SINGLE;
            rf_we_q    <= 1'b1;
            rf_waddr_q <= alu_rdst1;
            rf_wdata_q <= alu_result[DATA_W-1:0];
            hi_addr_q  <= alu_rdst2;
            hi_data_q  <= alu_result[2*DATA_W-1:DATA_W];
          end
        end
        WR_SINGLE: state_q <= IDLE;
        WR_LO: begin
          state_q    <= WR_HI;
          rf_we_q    <= 1'b1;
          rf_waddr_q <= hi_addr_q;
          rf_wdata_q <= hi_data_q;
        end
        WR_HI: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_ready = alu_grant;
  assign ld_ready  = ld_grant;
  assign busy      = (state_q != IDLE);
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign op_err    = op_err_q;
  assign wb_count  = wb_count_q;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: register-file data width; ALU result width is 2*DATA_W.
REQ-002 Parameter RA_W, default 4: register address width.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port alu_valid  input  1: ALU result offered.
REQ-006 Port alu_ready  output  1: sequencer accepts ALU result this cycle.
REQ-007 Port alu_op  input  6: opcode (select) of the offered result.
REQ-008 Port alu_result  input  2*DATA_W: ALU output; the upper half is meaningful only for MUL.
REQ-009 Port alu_rdst1 / alu_rdst2  input  RA_W each: low-half and high-half destination registers.
REQ-010 Port ld_valid / ld_ready  input / output  1 each: data-memory load return handshake.
REQ-011 Port ld_data  input  DATA_W, and ld_rdst  input  RA_W: load data and its destination register.
REQ-012 Port rf_we  output  1, rf_waddr  output  RA_W, rf_wdata  output  DATA_W: single register-file write port.
REQ-013 Port busy  output  1: high whenever the FSM state is not IDLE.
REQ-014 Port op_err  output  1: one-cycle pulse on acceptance of an illegal opcode.
REQ-015 Port wb_count  output  16: count of rf_we pulses, wrapping.

Function
REQ-016 FSM states: IDLE, WR_SINGLE, WR_LO, WR_HI.
REQ-017 alu_ready and ld_ready are combinational and can be high only in IDLE; at most one is high in any cycle.
REQ-018 IDLE arbitration when only one requester is valid: that requester is granted.
REQ-019 IDLE arbitration when both requesters are valid: round-robin; the requester not granted last is granted, and load wins the first conflict after reset.
REQ-020 An accepted transfer (valid && ready) is captured into holding registers on that edge; inputs are ignored until the FSM returns to IDLE.
REQ-021 Opcode classes: 000000, 000001 and 000100-010000 except 000111 -> single write of result[DATA_W-1:0] to rdst1.
REQ-022 Opcode 000111 (MUL) -> two writes: low half to rdst1, then high half to rdst2.
REQ-023 Opcodes 000010 (LOAD) and 000011 (STORE) on the ALU port -> consumed with no register write.
REQ-024 Opcodes above 010000 on the ALU port -> consumed with no register write; op_err pulses for one cycle in the cycle after acceptance.
REQ-025 IDLE transitions on acceptance: single-write class or load -> WR_SINGLE; MUL -> WR_LO; no-write class -> stays IDLE.
REQ-026 WR_SINGLE asserts rf_we for exactly one cycle with held address and data, then returns to IDLE.
REQ-027 WR_LO asserts rf_we with {rdst1, low half}, then moves to WR_HI.
REQ-028 WR_HI asserts rf_we with {rdst2, high half}, then returns to IDLE.
REQ-029 Latency: acceptance edge in cycle N gives rf_we in cycle N+1; the MUL high write is in cycle N+2.
REQ-030 Maximum throughput: one single write every 2 cycles; one MUL every 3 cycles.
REQ-031 When rdst1 == rdst2 on MUL, both writes still occur and the high half is left in the register.
REQ-032 rf_we, rf_waddr and rf_wdata are registered outputs; rf_waddr and rf_wdata are 0 whenever rf_we = 0.
REQ-033 wb_count increments by 1 per rf_we cycle and wraps from 16'hFFFF to 0.

Reset
REQ-034 While rst_n = 0: state = IDLE, all outputs = 0, holding registers = 0, round-robin pointer set so load wins the next conflict, wb_count = 0.
REQ-035 rst_n asserted mid-operation (WR_LO or WR_HI) aborts immediately; a pending high write is discarded and not replayed.
REQ-036 After rst_n deasserts, the first acceptance can occur in the first clock edge on which rst_n = 1.

Verification
REQ-037 ADD: op 000100, result 32'h0000_1234, rdst1 3 -> alu_ready high in IDLE; rf_we = 1 the next cycle with waddr 3, wdata 16'h1234; busy high for 1 cycle.
REQ-038 MUL: op 000111, result 32'hABCD_5678, rdst1 2, rdst2 5 -> cycle N+1 {we, addr 2, data 5678}; cycle N+2 {we, addr 5, data ABCD}; wb_count +2.
REQ-039 Conflict: ld_valid and alu_valid held high from reset for 4 grants -> grant order load, ALU, load, ALU; ld_ready and alu_ready never high together.
REQ-040 Illegal and STORE ops: op 010001 -> no rf_we and op_err pulses once; op 000011 -> no rf_we, no op_err, FSM stays in IDLE.
REQ-041 Reset mid-MUL: assert rst_n = 0 in the WR_HI cycle -> rf_we drops to 0 asynchronously, wb_count = 0, no high write after release.
REQ-042 Wrap: preload 65535 writes (or force wb_count) then one ADD -> wb_count = 0.
